hp_bar_anim: RTL

Downstream display stage of the battle FSM. It takes the current HP and max HP of one combatant, steps a displayed HP value toward the target one unit at a time on frame ticks, and converts it to a pixel width and a colour for the HP bar sprite. The battle FSM instantiates two copies (player, enemy). It holds its Player/Enemy-to-next-state advance until busy drops.

---
 rtl/battle_pkg.sv | 50 +++++
 rtl/hp_div.sv | 94 +++++++++
 rtl/hp_bar_anim.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/battle_pkg.sv
// Shared types and constants for the battle display path.
//   HP_W        : width of every HP quantity (current, max, displayed)
//   NUM_W       : width of the bar-width dividend (disp_hp * BAR_W)
//   bar_color_t : HP bar colour code driven to the sprite stage
//   hp_state_t  : hp_bar_anim controller states
//   hp_color()  : colour classification of disp_hp against max HP, no divide
package battle_pkg;

  localparam int HP_W  = 8;
  localparam int NUM_W = 15;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } bar_color_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_STEP = 3'd2,
    S_DIV  = 3'd3,
    S_FIN  = 3'd4
  } hp_state_t;

  // Threshold tests are done as 2*hp > max (above half) and 5*hp > max
  // (above a fifth) so no divider is needed. max == 0 means there is no
  // meaningful ratio, so the bar is shown empty and red.
  function automatic bar_color_t hp_color(input logic [HP_W-1:0] hp,
                                          input logic [HP_W-1:0] max_v);
    logic [HP_W+2:0] hp2;
    logic [HP_W+2:0] hp5;
    logic [HP_W+2:0] mx;
    bar_color_t      c;
    hp2 = {2'b00, hp, 1'b0};
    hp5 = {3'b000, hp} + {1'b0, hp, 2'b00};
    mx  = {3'b000, max_v};
    if (max_v == '0) begin
      c = RED;
    end else if (hp2 > mx) begin
      c = GREEN;
    end else if (hp5 > mx) begin
      c = YELLOW;
    end else begin
      c = RED;
    end
    return c;
  endfunction

endpackage

// File: rtl/hp_div.sv
// Sequential restoring divider, NUM_W-bit dividend by HP_W-bit divisor.
// Ports:
//   Clk, Reset : clock, asynchronous active-high reset
//   start      : one-Clk request; num/den are captured on this edge
//   num        : dividend (NUM_W bits)
//   den        : divisor (HP_W bits), zero allowed
//   quo        : quotient, valid while valid is high
//   valid      : one-Clk pulse when quo holds the finished result
//
// Handshake: start is a fire-and-forget request with no ready; a start
// while a division is running abandons it and begins the new one. valid is
// a one-cycle pulse, NUM_W Clk after start for a non-zero divisor, and one
// Clk after start when den == 0 (quotient forced to 0).
module hp_div
  import battle_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [HP_W-1:0]  den,
  output logic [NUM_W-1:0] quo,
  output logic             valid
);

  logic [HP_W-1:0]  rem_q;
  logic [HP_W-1:0]  den_q;
  logic [NUM_W-1:0] q_q;
  logic [3:0]       cnt_q;
  logic             run_q;

  logic [HP_W-1:0]  src_rem;
  logic [NUM_W-1:0] src_q;
  logic [HP_W-1:0]  den_use;
  logic [HP_W:0]    shifted;
  logic [HP_W-1:0]  rem_nxt;
  logic [NUM_W-1:0] q_nxt;

  // One restoring iteration. The start edge already performs the first
  // iteration on the incoming operands, so NUM_W iterations finish NUM_W
  // edges after start and the result is ready on the NUM_W-th cycle.
  always_comb begin
    src_rem = start ? '0  : rem_q;
    src_q   = start ? num : q_q;
    den_use = start ? den : den_q;
    shifted = {src_rem, src_q[NUM_W-1]};
    if (shifted >= {1'b0, den_use}) begin
      rem_nxt = 8'(shifted - {1'b0, den_use});
      q_nxt   = {src_q[NUM_W-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[HP_W-1:0];
      q_nxt   = {src_q[NUM_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rem_q <= '0;
      den_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        den_q <= den;
        if (den == '0) begin
          rem_q <= '0;
          q_q   <= '0;
          cnt_q <= '0;
          run_q <= 1'b0;
          valid <= 1'b1;
        end else begin
          rem_q <= rem_nxt;
          q_q   <= q_nxt;
          cnt_q <= 4'd1;
          run_q <= 1'b1;
        end
      end else if (run_q) begin
        rem_q <= rem_nxt;
        q_q   <= q_nxt;
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'(NUM_W - 1)) begin
          run_q <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

  assign quo = q_q;

endmodule

// File: rtl/hp_bar_anim.sv
// HP bar animator for one combatant. Walks the displayed HP toward the
// battle register value one unit per STEP_FRAMES frame ticks and converts
// it into a filled bar width and a colour.
// Ports:
//   Clk, Reset : clock, asynchronous active-high reset
//   frame_tick : one-Clk pulse per video frame, only counted in S_WAIT
//   load       : snap disp_hp to target_hp and recompute the bar (any state)
//   target_hp  : HP value to display
//   max_hp     : max HP of the combatant (0 allowed)
//   disp_hp    : HP currently shown
//   bar_px     : floor(disp_hp*BAR_W/max_hp), clamped to BAR_W
//   bar_color  : 0 green, 1 yellow, 2 red
//   busy       : high whenever the controller is outside S_IDLE
//   done       : one-Clk pulse when the display has settled on the target
//   state_dbg  : current controller state
module hp_bar_anim
  import battle_pkg::*;
#(
  parameter int BAR_W       = 48,
  parameter int STEP_FRAMES = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_tick,
  input  logic            load,
  input  logic [HP_W-1:0] target_hp,
  input  logic [HP_W-1:0] max_hp,
  output logic [HP_W-1:0] disp_hp,
  output logic [6:0]      bar_px,
  output logic [1:0]      bar_color,
  output logic            busy,
  output logic            done,
  output hp_state_t       state_dbg
);

  localparam logic [NUM_W-1:0] BAR_W_N   = NUM_W'(BAR_W);
  localparam logic [6:0]       BAR_W_PX  = 7'(BAR_W);
  localparam logic [3:0]       STEP_LAST = 4'(STEP_FRAMES - 1);

  hp_state_t       state_q, state_d;
  logic [HP_W-1:0] disp_d;
  logic [HP_W-1:0] tgt_q, tgt_d;
  logic [HP_W-1:0] max_q, max_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic [6:0]      px_d;
  bar_color_t      color_q, color_d;
  logic            done_d;

  logic             div_start;
  logic [NUM_W-1:0] div_num;
  logic [NUM_W-1:0] div_quo;
  logic             div_valid;

  // The divider is fed from the next-state values so the division starts on
  // the same edge that enters S_DIV.
  assign div_num = {{(NUM_W-HP_W){1'b0}}, disp_d} * BAR_W_N;

  hp_div u_div (
    .Clk   (Clk),
    .Reset (Reset),
    .start (div_start),
    .num   (div_num),
    .den   (max_d),
    .quo   (div_quo),
    .valid (div_valid)
  );

  always_comb begin
    state_d   = state_q;
    disp_d    = disp_hp;
    tgt_d     = tgt_q;
    max_d     = max_q;
    fcnt_d    = fcnt_q;
    px_d      = bar_px;
    color_d   = color_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    if (load) begin
      // Snap overrides everything, including a division in flight.
      state_d   = S_DIV;
      disp_d    = target_hp;
      tgt_d     = target_hp;
      max_d     = max_hp;
      div_start = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (target_hp != disp_hp) begin
            tgt_d   = target_hp;
            max_d   = max_hp;
            fcnt_d  = '0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (frame_tick) begin
            if (fcnt_q == STEP_LAST) begin
              fcnt_d  = '0;
              state_d = S_STEP;
            end else begin
              fcnt_d = fcnt_q + 4'd1;
            end
          end
        end
        S_STEP: begin
          if (tgt_q > disp_hp && disp_hp != '1) begin
            disp_d = disp_hp + 8'd1;
          end else if (tgt_q < disp_hp && disp_hp != '0) begin
            disp_d = disp_hp - 8'd1;
          end
          state_d   = S_DIV;
          div_start = 1'b1;
        end
        S_DIV: begin
          if (div_valid) begin
            px_d    = (div_quo > BAR_W_N) ? BAR_W_PX : div_quo[6:0];
            color_d = hp_color(disp_hp, max_q);
            state_d = S_FIN;
          end
        end
        S_FIN: begin
          if (disp_hp != tgt_q) begin
            fcnt_d  = '0;
            state_d = S_WAIT;
          end else if (target_hp != disp_hp) begin
            // Target moved while animating: continue toward the new value
            // without signalling done for the intermediate stop.
            tgt_d   = target_hp;
            max_d   = max_hp;
            fcnt_d  = '0;
            state_d = S_WAIT;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      disp_hp <= '0;
      tgt_q   <= '0;
      max_q   <= '0;
      fcnt_q  <= '0;
      bar_px  <= '0;
      color_q <= RED;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_hp <= disp_d;
      tgt_q   <= tgt_d;
      max_q   <= max_d;
      fcnt_q  <= fcnt_d;
      bar_px  <= px_d;
      color_q <= color_d;
      busy    <= (state_d != S_IDLE);
      done    <= done_d;
    end
  end

  assign bar_color = color_q;
  assign state_dbg = state_q;

endmodule
